// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS core: sequencer state encoding,
// opcode constants and the load classification used to stall EXEC1.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_HALT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC1  = 4'd3,
    S_EXEC2  = 4'd4
  } state_t;

  localparam logic [5:0]  OP_LW           = 6'b100011;
  // This core's encoding for LUI, which reads memory like the load group
  localparam logic [5:0]  OP_LUI          = 6'b011111;
  localparam logic [5:0]  LOAD_GROUP_MASK = 6'b111000;
  localparam logic [31:0] HALT_ADDR       = 32'h0000_0000;

  // The load group is every opcode sharing the top three bits of LW
  function automatic logic is_load(input logic [5:0] op);
    return ((op & LOAD_GROUP_MASK) == (OP_LW & LOAD_GROUP_MASK)) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/cpu_state_sequencer_if.sv
// Sequencer bundle: memory/multiplier status in, state code and counters out.
interface cpu_state_sequencer_if
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
);
  logic             waitrequest;
  logic [5:0]       opcode;
  logic             div_mult_busy;
  logic [31:0]      pc_next;
  state_t           state;
  logic             active;
  logic [CNT_W-1:0] instr_retired;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  waitrequest, opcode, div_mult_busy, pc_next,
    output state, active, instr_retired, stall_cycles
  );

  modport slave (
    output waitrequest, opcode, div_mult_busy, pc_next,
    input  state, active, instr_retired, stall_cycles
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + ONE;
    end
  end
endmodule

// File: rtl/cpu_state_sequencer.sv
// Multicycle state sequencer: HALT -> FETCH -> DECODE -> EXEC1 -> EXEC2 -> FETCH,
// with memory/multiplier stalls, jump-to-zero termination and perf counters.
module cpu_state_sequencer
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_state_sequencer_if.master bus
);
  state_t state_p0;
  logic   active_p0;
  logic   launched_p0;
  logic   hold;
  logic   retire;

  always_comb begin
    hold   = 1'b0;
    retire = 1'b0;
    case (state_p0)
      S_FETCH: hold = bus.waitrequest;
      S_EXEC1: hold = is_load(bus.opcode) && bus.waitrequest;
      S_EXEC2: begin
        hold   = bus.waitrequest || bus.div_mult_busy;
        retire = !(bus.waitrequest || bus.div_mult_busy);
      end
      default: ;
    endcase
  end

  // launched separates the power-on HALT (which launches) from the terminal HALT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0    <= S_HALT;
      active_p0   <= 1'b0;
      launched_p0 <= 1'b0;
    end else begin
      case (state_p0)
        S_HALT: begin
          if (!launched_p0) begin
            state_p0    <= S_FETCH;
            launched_p0 <= 1'b1;
            active_p0   <= 1'b1;
          end else begin
            active_p0 <= 1'b0;
          end
        end
        S_FETCH:  if (!hold) state_p0 <= S_DECODE;
        S_DECODE: state_p0 <= S_EXEC1;
        S_EXEC1:  if (!hold) state_p0 <= S_EXEC2;
        S_EXEC2: begin
          if (!hold) begin
            if (bus.pc_next == HALT_ADDR) begin
              state_p0  <= S_HALT;
              active_p0 <= 1'b0;
            end else begin
              state_p0 <= S_FETCH;
            end
          end
        end
        default: begin
          state_p0  <= S_HALT;
          active_p0 <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_retired (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .q     (bus.instr_retired)
  );

  sat_counter #(.W(CNT_W)) u_stalls (
    .clk   (clk),
    .reset (reset),
    .inc   (hold),
    .q     (bus.stall_cycles)
  );

  assign bus.state  = state_p0;
  assign bus.active = active_p0;
endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Directed bench for cpu_state_sequencer: a full-width instance plus a 3-bit
// counter instance driven identically to exercise counter saturation.
module tb_cpu_state_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cpu_state_sequencer_if #(.CNT_W(32)) bus ();
  cpu_state_sequencer_if #(.CNT_W(3))  bus_s ();

  cpu_state_sequencer #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  cpu_state_sequencer #(.CNT_W(3)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic busy, input logic [5:0] op, input logic [31:0] pc);
    bus.waitrequest     = wr;
    bus.div_mult_busy   = busy;
    bus.opcode          = op;
    bus.pc_next         = pc;
    bus_s.waitrequest   = wr;
    bus_s.div_mult_busy = busy;
    bus_s.opcode        = op;
    bus_s.pc_next       = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] exp);
    check(tag, 32'(bus.state), 32'(exp));
  endtask

  localparam logic [5:0]  OP_ADDIU = 6'b001001;
  localparam logic [31:0] PC_SEQ   = 32'h0000_0100;

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, OP_ADDIU, PC_SEQ);

    // Reset held three cycles
    repeat (3) tick();
    check_state("reset_state", 4'd0);
    check("reset_active", 32'(bus.active), 32'd0);
    check("reset_retired", bus.instr_retired, 32'd0);
    check("reset_stalls", bus.stall_cycles, 32'd0);
    reset = 1'b0;

    // Launch and one unstalled instruction
    tick(); check_state("launch_e1", 4'd1);
    check("launch_active", 32'(bus.active), 32'd1);
    tick(); check_state("launch_e2", 4'd2);
    tick(); check_state("launch_e3", 4'd3);
    tick(); check_state("launch_e4", 4'd4);
    tick(); check_state("launch_e5", 4'd1);
    check("retired_1", bus.instr_retired, 32'd1);

    // Fetch stall for three cycles
    drive(1'b1, 1'b0, 6'b100011, PC_SEQ);
    for (int i = 0; i < 3; i++) begin
      tick(); check_state($sformatf("fetch_hold_%0d", i), 4'd1);
    end
    drive(1'b0, 1'b0, 6'b100011, PC_SEQ);
    tick(); check_state("fetch_release", 4'd2);
    check("fetch_stalls", bus.stall_cycles, 32'd3);
    check("fetch_stalls_small", 32'(bus_s.stall_cycles), 32'd3);

    // Load in EXEC1 holds on waitrequest
    tick(); check_state("load_exec1", 4'd3);
    drive(1'b1, 1'b0, 6'b100011, PC_SEQ);
    tick(); check_state("load_hold_0", 4'd3);
    tick(); check_state("load_hold_1", 4'd3);
    drive(1'b0, 1'b0, 6'b100011, PC_SEQ);
    tick(); check_state("load_exec2", 4'd4);
    check("load_stalls", bus.stall_cycles, 32'd5);
    tick(); check_state("load_fetch", 4'd1);
    check("retired_2", bus.instr_retired, 32'd2);

    // Non-load in EXEC1 ignores waitrequest
    tick(); check_state("nl_decode", 4'd2);
    tick(); check_state("nl_exec1", 4'd3);
    drive(1'b1, 1'b0, OP_ADDIU, PC_SEQ);
    tick(); check_state("nl_exec2", 4'd4);
    check("nl_stalls", bus.stall_cycles, 32'd5);
    drive(1'b0, 1'b0, OP_ADDIU, PC_SEQ);
    tick(); check_state("nl_fetch", 4'd1);
    check("retired_3", bus.instr_retired, 32'd3);

    // Divide: busy ignored before EXEC2, then 32 hold cycles
    drive(1'b0, 1'b1, OP_ADDIU, PC_SEQ);
    tick(); check_state("div_decode", 4'd2);
    tick(); check_state("div_exec1", 4'd3);
    tick(); check_state("div_exec2", 4'd4);
    check("div_pre_stalls", bus.stall_cycles, 32'd5);
    for (int i = 0; i < 32; i++) begin
      drive(i < 4, 1'b1, OP_ADDIU, PC_SEQ);
      tick();
      check_state($sformatf("div_hold_%0d", i), 4'd4);
    end
    drive(1'b0, 1'b0, OP_ADDIU, PC_SEQ);
    tick(); check_state("div_exit", 4'd1);
    check("div_retired", bus.instr_retired, 32'd4);
    check("div_stalls", bus.stall_cycles, 32'd37);
    check("div_stalls_sat", 32'(bus_s.stall_cycles), 32'd7);

    // Fifth instruction jumps to zero
    drive(1'b0, 1'b0, OP_ADDIU, 32'h0);
    tick(); check_state("term_decode", 4'd2);
    tick(); check_state("term_exec1", 4'd3);
    tick(); check_state("term_exec2", 4'd4);
    check("term_active_pre", 32'(bus.active), 32'd1);
    tick(); check_state("term_halt", 4'd0);
    check("term_active", 32'(bus.active), 32'd0);
    check("term_retired", bus.instr_retired, 32'd5);
    check("term_retired_small", 32'(bus_s.instr_retired), 32'd5);

    // Terminal HALT ignores input activity
    for (int i = 0; i < 100; i++) begin
      drive(1'($urandom), 1'($urandom), 6'($urandom), $urandom | 32'h4);
      tick();
      check_state($sformatf("halt_stay_%0d", i), 4'd0);
      check($sformatf("halt_active_%0d", i), 32'(bus.active), 32'd0);
    end
    check("halt_retired", bus.instr_retired, 32'd5);
    check("halt_stalls", bus.stall_cycles, 32'd37);

    // Relaunch, then reset in the middle of an EXEC2 divide stall
    reset = 1'b1;
    drive(1'b0, 1'b0, OP_ADDIU, PC_SEQ);
    tick();
    reset = 1'b0;
    tick(); check_state("re_fetch", 4'd1);
    drive(1'b0, 1'b1, OP_ADDIU, PC_SEQ);
    tick(); tick(); tick();
    check_state("mid_exec2", 4'd4);
    tick(); tick();
    check_state("mid_hold", 4'd4);
    check("mid_stalls_pre", bus.stall_cycles, 32'd2);
    #2 reset = 1'b1;
    #1;
    check_state("mid_reset_state", 4'd0);
    check("mid_reset_active", 32'(bus.active), 32'd0);
    check("mid_reset_retired", bus.instr_retired, 32'd0);
    check("mid_reset_stalls", bus.stall_cycles, 32'd0);
    check("mid_reset_stalls_small", 32'(bus_s.stall_cycles), 32'd0);
    drive(1'b0, 1'b0, OP_ADDIU, PC_SEQ);
    tick(); tick();
    reset = 1'b0;
    tick(); check_state("relaunch_e1", 4'd1);
    check("relaunch_active", 32'(bus.active), 32'd1);
    tick(); check_state("relaunch_e2", 4'd2);
    tick(); check_state("relaunch_e3", 4'd3);
    tick(); check_state("relaunch_e4", 4'd4);
    tick(); check_state("relaunch_e5", 4'd1);
    check("relaunch_retired", bus.instr_retired, 32'd1);
    check("relaunch_stalls", bus.stall_cycles, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_state_sequencer.md
# cpu_state_sequencer

Multicycle state sequencer for the MIPS core. It produces the 4-bit `state` code consumed by `control_unit` and advances HALT → FETCH → DECODE → EXEC1 → EXEC2 → FETCH. It stalls on Avalon `waitrequest` and on a busy multiplier/divider, and detects program termination, which is a jump to address 0. It also keeps retired-instruction and stall-cycle counters for the testbench and debug.

## Interface
Parameters:
- `CNT_W`, default 32: width of both performance counters.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `waitrequest` input 1: Avalon stall from memory.
- `opcode` input 6: opcode field from the instruction register (valid from EXEC1).
- `div_mult_busy` input 1: high while the multiply/divide unit is computing.
- `pc_next` input 32: PC value that will be written when `pcwrite` fires in EXEC2.
- `state` output 4: 0=HALT, 1=FETCH, 2=DECODE, 3=EXEC1, 4=EXEC2.
- `active` output 1: high from launch until termination.
- `instr_retired` output CNT_W: count of instructions completed.
- `stall_cycles` output CNT_W: count of cycles spent held in any state.

## Operation
- `launched` is an internal flag. It separates power-on HALT from terminated HALT.
- **HALT**
  - If `!launched`: go to FETCH next cycle and set `launched=1`, `active=1`.
  - If `launched`: stay in HALT with `active=0` until reset.
- **FETCH**
  - Hold while `waitrequest`.
  - Otherwise go to DECODE.
- **DECODE**
  - Unconditional single cycle, then EXEC1.
- **EXEC1**
  - `is_load` = (`opcode[5:3]==3'b100`) | (`opcode==6'b011111`).
  - Hold while `is_load & waitrequest`.
  - Otherwise go to EXEC2.
- **EXEC2**
  - Hold while `waitrequest | div_mult_busy`. This keeps the sequencer consistent with `pcwrite = exec2 & !waitrequest`.
  - On exit, increment `instr_retired`.
  - If `pc_next==32'h0000_0000`: go to HALT and clear `active`.
  - Otherwise go to FETCH.
- **Stalls:** `stall_cycles` increments on every cycle a hold condition above is true.
- **Counters:** both saturate at all-ones and never wrap.
- **Illegal state:** encodings 5–15 must recover to HALT on the next edge, with `active=0`. They are never reached in normal operation.

## Timing
- **Reset values:**
  - `state=0`
  - `active=0`
  - `launched=0`
  - `instr_retired=0`
  - `stall_cycles=0`
- **Mid-operation reset:** asserting `reset` in any state forces the reset values immediately (asynchronously). This includes clearing the counters.
- **After reset release:**
  - 1st rising edge: HALT → FETCH, `active` rises.
  - Minimum instruction latency is 4 cycles (FETCH, DECODE, EXEC1, EXEC2) with no stalls.
- **Same-cycle events:**
  - `waitrequest` and `div_mult_busy` both high in EXEC2: one hold cycle, counted once in `stall_cycles`.
  - `div_mult_busy` is ignored outside EXEC2.
  - `waitrequest` is ignored in DECODE and HALT, and in EXEC1 for non-loads.
- **Termination:**
  - `active` falls on the same edge that `state` enters HALT.
  - `instr_retired` includes the terminating jump.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `cpu_pkg` holds:
  - `state_t`, a 4-bit enum: `S_HALT=0`, `S_FETCH=1`, `S_DECODE=2`, `S_EXEC1=3`, `S_EXEC2=4`. `control_unit` migrates to the same enum.
  - Opcode constants `OP_LW`, `OP_LUI` and the load-group mask.
  - `HALT_ADDR = 32'h0`.
- Sub-module `sat_counter #(W)`: inputs `clk`, `reset`, `inc`; output `q`. Instantiated twice.

## Test plan
- **Reset and launch:** hold `reset` for 3 cycles, then release.
  - Required: `state`=0 with `active`=0 during reset.
  - Edge 1: `state`=1 and `active`=1.
  - Edges 2–5: `state`=2,3,4,1.
- **Fetch stall:** hold `waitrequest` high for 3 cycles in FETCH.
  - Required: `state` stays 1 for 3 cycles, then goes to 2.
  - `stall_cycles`=3.
- **Load vs. non-load in EXEC1:** `waitrequest` high for 2 cycles in EXEC1.
  - With `opcode=6'b100011`: EXEC1 lasts 3 cycles.
  - With `opcode=6'b001001`: EXEC1 lasts 1 cycle.
- **Divide:** `div_mult_busy` high for 32 cycles in EXEC2.
  - Required: EXEC2 held for 32 cycles, then FETCH.
  - `instr_retired` +1 and `stall_cycles` +32.
- **Termination:** `pc_next`=0 on EXEC2 exit after 5 instructions.
  - Required: `state`=0, `active`=0, `instr_retired`=5.
  - The sequencer stays in HALT for 100 cycles despite input activity.
- **Reset mid-stall:** assert `reset` during an EXEC2 divide stall.
  - Required: immediate `state`=0 and counters=0.
  - Normal relaunch after release.
